// File: rtl/id_ex_bypass.sv
// ID/EX pipeline register with EX/MEM operand bypass and load-use stall.
// Optional hazard counters (stall_cnt, fwd_cnt) are built when HAZ_STATS_EN is defined.
module id_ex_bypass #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_p0,
  input  logic [DW-1:0] id_p1,
  input  logic [AW-1:0] id_p0_addr,
  input  logic [AW-1:0] id_p1_addr,
  input  logic          id_re0,
  input  logic          id_re1,
  input  logic [AW-1:0] id_dst_addr,
  input  logic          id_we,
  input  logic          id_mem_rd,
  input  logic          flush,
  input  logic [DW-1:0] ex_result,
  input  logic [AW-1:0] mem_dst_addr,
  input  logic          mem_we,
  input  logic [DW-1:0] mem_result,
  output logic          ex_valid,
  output logic [DW-1:0] ex_op0,
  output logic [DW-1:0] ex_op1,
  output logic [AW-1:0] ex_dst_addr,
  output logic          ex_we,
  output logic          ex_mem_rd,
  output logic          stall_id
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   fwd_cnt
`endif
);

  logic          vld_p0;
  logic [DW-1:0] op0_p0;
  logic [DW-1:0] op1_p0;
  logic [AW-1:0] dst_p0;
  logic          we_p0;
  logic          mrd_p0;

  logic          ex_fwd_ok;
  logic          ex_hit0, ex_hit1, mem_hit0, mem_hit1;
  logic          use0, use1;
  logic          hazard;
  logic          capture;
  logic [DW-1:0] op0_d, op1_d;

  // A load in EX has no result yet, so it never feeds the EX bypass path.
  assign ex_fwd_ok = vld_p0 && we_p0 && !mrd_p0;
  assign use0      = id_re0 && (id_p0_addr != '0);
  assign use1      = id_re1 && (id_p1_addr != '0);

  always_comb begin
    ex_hit0  = use0 && ex_fwd_ok && (dst_p0 == id_p0_addr);
    ex_hit1  = use1 && ex_fwd_ok && (dst_p0 == id_p1_addr);
    mem_hit0 = use0 && mem_we && (mem_dst_addr == id_p0_addr);
    mem_hit1 = use1 && mem_we && (mem_dst_addr == id_p1_addr);

    op0_d = id_p0;
    if (ex_hit0)       op0_d = ex_result;
    else if (mem_hit0) op0_d = mem_result;

    op1_d = id_p1;
    if (ex_hit1)       op1_d = ex_result;
    else if (mem_hit1) op1_d = mem_result;
  end

  assign hazard = id_valid && vld_p0 && mrd_p0 && (dst_p0 != '0) &&
                  ((id_re0 && (id_p0_addr == dst_p0)) ||
                   (id_re1 && (id_p1_addr == dst_p0)));

  // A redirect discards the decode slot, so there is nothing left to hold.
  assign stall_id = hazard && !flush;
  assign capture  = !flush && !stall_id;

  // ---- ID -> EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      we_p0  <= 1'b0;
      mrd_p0 <= 1'b0;
      dst_p0 <= '0;
      op0_p0 <= '0;
      op1_p0 <= '0;
    end else if (!capture) begin
      vld_p0 <= 1'b0;
      we_p0  <= 1'b0;
      mrd_p0 <= 1'b0;
    end else begin
      vld_p0 <= id_valid;
      we_p0  <= id_we && id_valid;
      mrd_p0 <= id_mem_rd && id_valid;
      dst_p0 <= id_dst_addr;
      op0_p0 <= op0_d;
      op1_p0 <= op1_d;
    end
  end

  assign ex_valid    = vld_p0;
  assign ex_op0      = op0_p0;
  assign ex_op1      = op1_p0;
  assign ex_dst_addr = dst_p0;
  assign ex_we       = we_p0;
  assign ex_mem_rd   = mrd_p0;

`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] fwd_cnt_q;
  logic        fwd_any;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  assign fwd_any = ex_hit0 || mem_hit0 || ex_hit1 || mem_hit1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall_id)
        stall_cnt_q <= sat_inc(stall_cnt_q);
      if (capture && id_valid && fwd_any)
        fwd_cnt_q <= sat_inc(fwd_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_bypass.sv
// Scoreboard bench for id_ex_bypass: directed decode vectors push expected EX
// contents; a monitor pops and compares whenever ex_valid is presented.
module tb_id_ex_bypass;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [DW-1:0] id_p0 = '0, id_p1 = '0;
  logic [AW-1:0] id_p0_addr = '0, id_p1_addr = '0;
  logic          id_re0 = 1'b0, id_re1 = 1'b0;
  logic [AW-1:0] id_dst_addr = '0;
  logic          id_we = 1'b0, id_mem_rd = 1'b0, flush = 1'b0;
  logic [DW-1:0] ex_result = '0;
  logic [AW-1:0] mem_dst_addr = '0;
  logic          mem_we = 1'b0;
  logic [DW-1:0] mem_result = '0;
  logic          ex_valid;
  logic [DW-1:0] ex_op0, ex_op1;
  logic [AW-1:0] ex_dst_addr;
  logic          ex_we, ex_mem_rd, stall_id;
`ifdef HAZ_STATS_EN
  logic [15:0]   stall_cnt, fwd_cnt;
`endif

  id_ex_bypass #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_p0(id_p0), .id_p1(id_p1), .id_p0_addr(id_p0_addr), .id_p1_addr(id_p1_addr),
    .id_re0(id_re0), .id_re1(id_re1), .id_dst_addr(id_dst_addr),
    .id_we(id_we), .id_mem_rd(id_mem_rd), .flush(flush),
    .ex_result(ex_result), .mem_dst_addr(mem_dst_addr), .mem_we(mem_we),
    .mem_result(mem_result), .ex_valid(ex_valid), .ex_op0(ex_op0), .ex_op1(ex_op1),
    .ex_dst_addr(ex_dst_addr), .ex_we(ex_we), .ex_mem_rd(ex_mem_rd), .stall_id(stall_id)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] op0;
    logic [15:0] op1;
    logic [3:0]  dst;
    logic        we;
    logic        mrd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic fwd(input logic [15:0] exr, input logic mw, input logic [3:0] md,
                     input logic [15:0] mr);
    ex_result = exr; mem_we = mw; mem_dst_addr = md; mem_result = mr;
  endtask

  task automatic dec(input logic v, input logic [15:0] p0, input logic [15:0] p1,
                     input logic [3:0] a0, input logic [3:0] a1, input logic r0,
                     input logic r1, input logic [3:0] d, input logic w, input logic m,
                     input logic f);
    id_valid = v; id_p0 = p0; id_p1 = p1; id_p0_addr = a0; id_p1_addr = a1;
    id_re0 = r0; id_re1 = r1; id_dst_addr = d; id_we = w; id_mem_rd = m; flush = f;
  endtask

  task automatic expect_cap(input logic [15:0] o0, input logic [15:0] o1,
                            input logic [3:0] d, input logic w, input logic m);
    sb_q.push_back('{o0, o1, d, w, m});
  endtask

  task automatic idle();
    @(negedge clk);
    fwd(16'h0, 1'b0, 4'd0, 16'h0);
    dec(1'b0, 16'h0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef HAZ_STATS_EN
  // Load into Rk, dependent read stalls one cycle, then MEM supplies the data.
  task automatic load_use(input logic [3:0] k);
    @(negedge clk);
    fwd(16'h0, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h0, 16'h0, 4'd0, 4'd0, 1'b1, 1'b1, k, 1'b1, 1'b1, 1'b0);
    #1 check("lu_prod_stall", {31'd0, stall_id}, 32'd0);
    expect_cap(16'h0, 16'h0, k, 1'b1, 1'b1);
    @(negedge clk);
    dec(1'b1, 16'h1111, 16'h2222, k, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 check("lu_stall", {31'd0, stall_id}, 32'd1);
    @(negedge clk);
    fwd(16'h0, 1'b1, k, 16'hB000 + {12'd0, k});
    #1 check("lu_release", {31'd0, stall_id}, 32'd0);
    expect_cap(16'hB000 + {12'd0, k}, 16'h2222, 4'd0, 1'b0, 1'b0);
  endtask
`endif

  always @(posedge clk) begin
    #1;
    if (rst_n && ex_valid) begin
      if (sb_q.size() == 0) begin
        check("ex_valid_unexpected", {31'd0, ex_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("ex_op0", {16'd0, ex_op0}, {16'd0, mon_e.op0});
        check("ex_op1", {16'd0, ex_op1}, {16'd0, mon_e.op1});
        check("ex_dst_addr", {28'd0, ex_dst_addr}, {28'd0, mon_e.dst});
        check("ex_we", {31'd0, ex_we}, {31'd0, mon_e.we});
        check("ex_mem_rd", {31'd0, ex_mem_rd}, {31'd0, mon_e.mrd});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a live decode slot
    fwd(16'hFFFF, 1'b1, 4'd1, 16'hFFFF);
    dec(1'b1, 16'h1234, 16'h0000, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ex_we", {31'd0, ex_we}, 32'd0);
    check("rst_ex_mem_rd", {31'd0, ex_mem_rd}, 32'd0);
    check("rst_ex_op0", {16'd0, ex_op0}, 32'd0);
    check("rst_ex_op1", {16'd0, ex_op1}, 32'd0);
    check("rst_ex_dst", {28'd0, ex_dst_addr}, 32'd0);
    check("rst_stall", {31'd0, stall_id}, 32'd0);

    // First instruction after release
    rst_n = 1'b1;
    fwd(16'h0, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h1234, 16'h0000, 4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    #1 check("s1_stall", {31'd0, stall_id}, 32'd0);
    expect_cap(16'h1234, 16'h0000, 4'd7, 1'b1, 1'b0);

    // ADD R3, no dependence on R7 in EX
    @(negedge clk);
    dec(1'b1, 16'h0011, 16'h0022, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    expect_cap(16'h0011, 16'h0022, 4'd3, 1'b1, 1'b0);

    // EX bypass of R3 on port 1
    @(negedge clk);
    fwd(16'h00AA, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h4444, 16'h5555, 4'd4, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    expect_cap(16'h4444, 16'h00AA, 4'd5, 1'b1, 1'b0);

    // EX and MEM both write R5: EX wins; dst R0 with we passes through
    @(negedge clk);
    fwd(16'h0001, 1'b1, 4'd5, 16'h0002);
    dec(1'b1, 16'h9999, 16'h6666, 4'd5, 4'd6, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_cap(16'h0001, 16'h6666, 4'd0, 1'b1, 1'b0);

    // Reading R0 while EX and MEM both target R0: no forwarding
    @(negedge clk);
    fwd(16'h0BAD, 1'b1, 4'd0, 16'h0BAD);
    dec(1'b1, 16'h7777, 16'h5151, 4'd0, 4'd9, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    expect_cap(16'h7777, 16'h5151, 4'd2, 1'b0, 1'b0);

    // MEM hit on port 0; EX targets R2 but does not write; decode is LW R2
    @(negedge clk);
    fwd(16'h2222, 1'b1, 4'd8, 16'h8888);
    dec(1'b1, 16'h1010, 16'h2020, 4'd8, 4'd2, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    expect_cap(16'h8888, 16'h2020, 4'd2, 1'b1, 1'b1);

    // Load-use on R2: one stall cycle
    @(negedge clk);
    fwd(16'h5A5A, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'hDEAD, 16'h3333, 4'd2, 4'd3, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
    #1 check("lu_stall", {31'd0, stall_id}, 32'd1);

    // Load now in MEM: bubble in EX, stall drops, MEM supplies load data
    @(negedge clk);
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    fwd(16'h0, 1'b1, 4'd2, 16'hBEEF);
    #1 check("lu_release", {31'd0, stall_id}, 32'd0);
    expect_cap(16'hBEEF, 16'h3333, 4'd4, 1'b1, 1'b0);

    // EX writes R4: re0=0 keeps RF data, port 1 takes EX; decode is LW R2
    @(negedge clk);
    fwd(16'h4040, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'hAAAA, 16'hBBBB, 4'd4, 4'd4, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
    expect_cap(16'hAAAA, 16'h4040, 4'd2, 1'b1, 1'b1);

    // Load-use with flush: no stall, decode slot discarded
    @(negedge clk);
    fwd(16'h0, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h0000, 16'h1111, 4'd5, 4'd2, 1'b0, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
    #1 check("flush_stall", {31'd0, stall_id}, 32'd0);

    // Flushed slot left a bubble; now an id_valid=0 slot
    @(negedge clk);
    check("flush_bubble", {31'd0, ex_valid}, 32'd0);
    dec(1'b0, 16'hCCCC, 16'hCCCC, 4'd2, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0);
    #1 check("invalid_stall", {31'd0, stall_id}, 32'd0);

    @(negedge clk);
    check("invalid_bubble", {31'd0, ex_valid}, 32'd0);
    dec(1'b1, 16'h0F0F, 16'h0F0F, 4'd1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
    expect_cap(16'h0F0F, 16'h0F0F, 4'd1, 1'b0, 1'b1);

    // Load in EX targets R1, decode reads only R0: no stall; decode is LW R6
    @(negedge clk);
    dec(1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b0);
    #1 check("r0_no_stall", {31'd0, stall_id}, 32'd0);
    expect_cap(16'h0000, 16'h0000, 4'd6, 1'b1, 1'b1);

    // Reset asserted in the middle of a load-use stall
    @(negedge clk);
    dec(1'b1, 16'h0001, 16'h0002, 4'd3, 4'd6, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    #1 check("rst_mid_stall_pre", {31'd0, stall_id}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_mid_stall", {31'd0, stall_id}, 32'd0);
    check("rst_mid_mem_rd", {31'd0, ex_mem_rd}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    dec(1'b1, 16'h6060, 16'h0707, 4'd6, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 check("post_rst_stall", {31'd0, stall_id}, 32'd0);
    expect_cap(16'h6060, 16'h0707, 4'd0, 1'b0, 1'b0);

`ifdef HAZ_STATS_EN
    for (int k = 1; k <= 3; k++) load_use(4'(k));
    @(negedge clk);
    fwd(16'h0, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_cap(16'h0000, 16'h0000, 4'd9, 1'b1, 1'b0);
    @(negedge clk);
    fwd(16'h0099, 1'b0, 4'd0, 16'h0);
    dec(1'b1, 16'h0001, 16'h0002, 4'd9, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    expect_cap(16'h0099, 16'h0002, 4'd9, 1'b1, 1'b0);
    @(negedge clk);
    dec(1'b1, 16'h0003, 16'h0004, 4'd0, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_cap(16'h0003, 16'h0099, 4'd0, 1'b0, 1'b0);
    idle();
    #1 check("stall_cnt", {16'd0, stall_cnt}, 32'd3);
    check("fwd_cnt", {16'd0, fwd_cnt}, 32'd5);
    dut.stall_cnt_q = 16'hFFFF;
    dut.fwd_cnt_q   = 16'hFFFF;
    load_use(4'd1);
    idle();
    #1 check("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    check("fwd_cnt_sat", {16'd0, fwd_cnt}, 32'h0000FFFF);
`endif

    repeat (3) idle();
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
